ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register of the MIPS core with valid/ready handshake and a 2-entry skid buffer.
//  Captures ALU result, store data and MEM/WB control from the EX stage and presents them to the MEM stage.
//  Also drives the EX-stage forwarding path from its output entry.
//  Holds MEM-bound traffic whenever the data-memory port back-pressures, without dropping or reordering.
// PARAMETERS
//  DATA_W  32  ALU result / store data width (equals REG_WIDTH from the shared defines)
//  RA_W    5   register address width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  flush         in   1       synchronous kill of all held entries (branch/exception)
//  in_valid      in   1       EX beat valid
//  in_ready      out  1       stage can accept a beat
//  in_result     in   DATA_W  ALU result / memory address
//  in_store_data in   DATA_W  rt value for sw
//  in_rd         in   RA_W    destination register
//  in_regwrite   in   1       writes register file
//  in_memread    in   1       load
//  in_memwrite   in   1       store
//  in_mem2reg    in   1       WB selects memory data
//  out_valid     out  1       MEM beat valid
//  out_ready     in   1       MEM stage accepts
//  out_result, out_store_data, out_rd, out_regwrite, out_memread, out_memwrite, out_mem2reg  out  as in_*
//  fwd_valid     out  1       forwarding hit available
//  fwd_rd        out  RA_W    forwarded register
//  fwd_result    out  DATA_W  forwarded value
//  stall_cnt     out  32      back-pressure cycle count (EXMEM_STALL_CNT_EN only)
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state changes on posedge clk.
//  - States: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
//  - EMPTY: in_fire -> ONE, beat into main.
//  - ONE: in_fire & !out_fire -> FULL, beat into skid.
//  - ONE: in_fire & out_fire -> ONE, beat into main.
//  - ONE: out_fire only -> EMPTY.
//  - FULL: out_fire -> ONE, skid moves to main. in_ready=0, so no in_fire is possible.
//  - in_ready = (state != FULL), a function of registered state only (no comb path from out_ready).
//  - out_valid = (state != EMPTY). out_* hold main entry; they are stable while out_valid & !out_ready.
//  - Latency: 1 cycle accept->out_valid when EMPTY. Order strictly FIFO.
//  - in_rd==0 with in_regwrite=1: regwrite is stored as 0 ($zero never written).
//  - flush: next state EMPTY and both entries invalid. Wins over a same-cycle in_fire, which is dropped,
//    and over a same-cycle out_fire (the MEM stage still sees that beat this cycle).
//  - fwd_valid = out_valid & out_regwrite & !out_memread (load data is not yet known);
//    fwd_rd = out_rd; fwd_result = out_result.
//  - Reset (rst=1, async): state EMPTY, all out_* and fwd_* 0, in_ready=1 on release.
//    Beats presented while rst=1 are discarded. Reset mid-transfer loses held entries by design.
// CONFIGURATION
//  EXMEM_STALL_CNT_EN defined: 32-bit stall_cnt.
//    +1 per cycle with out_valid & !out_ready; saturates at 32'hFFFF_FFFF.
//    Cleared by rst only (not by flush).
//  EXMEM_STALL_CNT_EN undefined: stall_cnt port and counter logic absent.
// STRUCTURE
//  - Shared defines file: DATA_W/REG_WIDTH, RA_W, state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2),
//    payload field offsets/width.
//  - Sub-module pipe_skid_buf: generic 2-entry valid/ready skid buffer parameterised by payload width.
//    ex_mem_stage packs/unpacks the payload and adds the $zero rule, forwarding and stall counter.
// TESTING
//  1. Reset then one beat result=32'h0000_0010, rd=5, regwrite=1, out_ready=1
//     -> out_valid next cycle, out_result=0x10; fwd_valid=1, fwd_rd=5.
//  2. out_ready=0, three back-to-back beats A,B,C -> A,B accepted; in_ready=0 after B; C held upstream.
//     Release out_ready -> A,B,C delivered in order, no duplicates.
//  3. FULL state + flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; neither entry nor new beat appears.
//  4. Beat rd=0, regwrite=1 -> out_regwrite=0, fwd_valid=0. Load beat (memread=1, rd=7) -> fwd_valid=0.
//  5. rst asserted mid-cycle while FULL -> outputs 0 immediately (async); after release, state EMPTY, in_ready=1.
//  6. EXMEM_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10; flush leaves it 10.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline register.
// Provides the default datapath widths, the skid-buffer state encodings and a
// helper for the $zero write-suppression rule.
package ex_mem_stage_pkg;

  localparam int REG_WIDTH    = 32;
  localparam int EXMEM_DATA_W = REG_WIDTH;
  localparam int EXMEM_RA_W   = 5;

  // Control bits carried alongside the two data words and rd:
  // {regwrite, memread, memwrite, mem2reg}
  localparam int EXMEM_CTRL_W = 4;

  typedef logic [1:0] skid_state_t;

  localparam skid_state_t ST_EMPTY = 2'd0;
  localparam skid_state_t ST_ONE   = 2'd1;
  localparam skid_state_t ST_FULL  = 2'd2;

  // $zero is never a real write target, so its regwrite is dropped at capture.
  function automatic logic wb_enable(input logic regwrite, input logic rd_nonzero);
    return regwrite & rd_nonzero;
  endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to the producer. Entries leave in arrival order.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | nothing held
// ST_ONE   | main entry valid (driving out_data)
// ST_FULL  | main and skid valid, upstream stalled
//
// Ports: clk, rst (async, active-high), flush (sync kill of both entries),
//        in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module pipe_skid_buf
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (in_fire && out_fire) begin
          main_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides everything; the beat leaving this cycle is still seen downstream.
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready handshake and a
// 2-entry skid buffer. Packs EX results and MEM/WB control into one payload,
// suppresses writes to $zero, and drives the EX forwarding path from the
// entry currently presented to MEM.
//
// Ports: clk, rst (async, active-high), flush;
//        in_valid/in_ready + in_result, in_store_data, in_rd, in_regwrite,
//        in_memread, in_memwrite, in_mem2reg;
//        out_valid/out_ready + matching out_* fields;
//        fwd_valid, fwd_rd, fwd_result;
//        stall_cnt (only when EXMEM_STALL_CNT_EN is defined).
//
// Build option EXMEM_STALL_CNT_EN: adds a saturating 32-bit count of cycles
// where MEM back-pressures a valid beat. Cleared only by rst.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int RA_W   = EXMEM_RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_mem2reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_mem2reg,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_result
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PAYLOAD_W = 2 * DATA_W + RA_W + EXMEM_CTRL_W;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  assign in_payload = {in_result, in_store_data, in_rd,
                       wb_enable(in_regwrite, in_rd != '0),
                       in_memread, in_memwrite, in_mem2reg};

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_result, out_store_data, out_rd,
          out_regwrite, out_memread, out_memwrite, out_mem2reg} = out_payload;

  // Load data only exists after MEM, so loads cannot forward from here.
  assign fwd_valid  = out_valid & out_regwrite & ~out_memread;
  assign fwd_rd     = out_rd;
  assign fwd_result = out_result;

`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memread, in_memwrite, in_mem2reg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_memread, out_memwrite, out_mem2reg;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_result;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .in_regwrite    (in_regwrite),
    .in_memread     (in_memread),
    .in_memwrite    (in_memwrite),
    .in_mem2reg     (in_mem2reg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_regwrite   (out_regwrite),
    .out_memread    (out_memread),
    .out_memwrite   (out_memwrite),
    .out_mem2reg    (out_mem2reg),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_result     (fwd_result)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        mem2reg;
  } beat_t;

  // Reference model: an ordered list of beats held by the stage (at most two).
  beat_t       q[$];
  beat_t       delivered[$];
  logic [31:0] exp_stall = 32'd0;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic m2r);
    beat_t b;
    b.result = res; b.store_data = sd; b.rd = rd;
    b.regwrite = rw; b.memread = mr; b.memwrite = mw; b.mem2reg = m2r;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    return mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  task automatic check_model();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_store_data", out_store_data, q[0].store_data);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_ctrl", {out_regwrite, out_memread, out_memwrite, out_mem2reg},
          {q[0].regwrite, q[0].memread, q[0].memwrite, q[0].mem2reg});
      chk("fwd_valid", fwd_valid, q[0].regwrite && !q[0].memread);
      chk("fwd_rd", fwd_rd, q[0].rd);
      chk("fwd_result", fwd_result, q[0].result);
    end else begin
      chk("fwd_valid_empty", fwd_valid, 1'b0);
    end
`ifdef EXMEM_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  // One clock: drive inputs at the falling edge, check state, then advance the model
  // to what the following rising edge should produce.
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input beat_t b);
    logic acc, dlv;
    beat_t s;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl;
    in_result = b.result; in_store_data = b.store_data; in_rd = b.rd;
    in_regwrite = b.regwrite; in_memread = b.memread;
    in_memwrite = b.memwrite; in_mem2reg = b.mem2reg;
    check_model();
    acc = iv && (q.size() < 2);
    dlv = ordy && (q.size() != 0);
    if ((q.size() != 0) && !ordy && (exp_stall != 32'hFFFF_FFFF)) exp_stall++;
    if (dlv) delivered.push_back(q.pop_front());
    if (fl) q.delete();
    else if (acc) begin
      s = b;
      s.regwrite = b.regwrite && (b.rd != 5'd0);
      q.push_back(s);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_payload"}, {out_result, out_store_data}, 64'd0);
    chk({tag, "_out_rd_ctrl"}, {out_rd, out_regwrite, out_memread, out_memwrite, out_mem2reg}, 9'd0);
    chk({tag, "_fwd"}, {fwd_valid, fwd_rd, fwd_result}, 38'd0);
  endtask

  beat_t idle, a, b, c;
  int    n0;

  initial begin
    idle = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with a beat presented: nothing may be captured.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_result = 32'hDEAD_BEEF; in_store_data = 32'h1234_5678; in_rd = 5'd9;
    in_regwrite = 1'b1; in_memread = 1'b0; in_memwrite = 1'b1; in_mem2reg = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    chk("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0;

    // Single beat, 1-cycle latency, forwarded.
    a = mk(32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, a);
    cycle(1'b0, 1'b1, 1'b0, idle);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_result", out_result, 32'h10);
    chk("t1_fwd_valid", fwd_valid, 1'b1);
    chk("t1_fwd_rd", fwd_rd, 5'd5);

    // Back-pressure: A,B accepted, C held upstream, all delivered in order.
    a = mk(32'hA, 32'h1A, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    b = mk(32'hB, 32'h1B, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    c = mk(32'hC, 32'h1C, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    n0 = delivered.size();
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 1'b0, b);
    cycle(1'b1, 1'b0, 1'b0, c);
    chk("t2_in_ready_full", in_ready, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, c);
    cycle(1'b1, 1'b1, 1'b0, c);
    cycle(1'b0, 1'b1, 1'b0, idle);
    cycle(1'b0, 1'b1, 1'b0, idle);
    chk("t2_count", delivered.size() - n0, 3);
    chk("t2_order", {delivered[n0].result[7:0], delivered[n0+1].result[7:0], delivered[n0+2].result[7:0]},
        24'h0A0B0C);

    // Flush while FULL with a beat offered, then while ONE with an accepted beat.
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 1'b0, b);
    cycle(1'b1, 1'b0, 1'b1, c);
    cycle(1'b0, 1'b0, 1'b0, idle);
    chk("t3_out_valid", out_valid, 1'b0);
    chk("t3_in_ready", in_ready, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b1, 1'b1, b);
    cycle(1'b0, 1'b0, 1'b0, idle);
    chk("t3b_out_valid", out_valid, 1'b0);

    // $zero write suppression and load forwarding block.
    cycle(1'b1, 1'b1, 1'b0, mk(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk(32'h1000, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1));
    chk("t4_rd0_regwrite", out_regwrite, 1'b0);
    chk("t4_rd0_fwd", fwd_valid, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, idle);
    chk("t4_load_rd", out_rd, 5'd7);
    chk("t4_load_fwd", fwd_valid, 1'b0);

    // Async reset mid-cycle while FULL.
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 1'b0, b);
    cycle(1'b1, 1'b0, 1'b0, c);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("t5_async");
    q.delete();
    exp_stall = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_out_valid", out_valid, 1'b0);

    // Stall counter: 10 stalled cycles, flush does not clear it.
    cycle(1'b1, 1'b0, 1'b0, a);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, idle);
    cycle(1'b0, 1'b1, 1'b1, idle);
`ifdef EXMEM_STALL_CNT_EN
    chk("t6_stall_10", stall_cnt, 32'd10);
`endif
    cycle(1'b0, 1'b0, 1'b0, idle);
`ifdef EXMEM_STALL_CNT_EN
    chk("t6_stall_after_flush", stall_cnt, 32'd10);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0), rand_beat());
    end
    cycle(1'b0, 1'b1, 1'b0, idle);
    cycle(1'b0, 1'b1, 1'b0, idle);
    cycle(1'b0, 1'b1, 1'b0, idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
